sp_ram_load_arbiter: RTL
========================

// Module: sp_ram_load_arbiter
// PURPOSE
// Upstream front end of the single-port RAM wrapper. Multiplexes the core LSU-style port (req/gnt/rvalid)
// with a byte-stream program loader (e.g. SPI/debug preload). Packs loader bytes little-endian into 32-bit
// words and writes them through the RAM port with byte enables; core is stalled while a load is active.
// PARAMETERS
// RAM_SIZE    32768              RAM size in bytes; word pointer wraps modulo RAM_SIZE/4
// ADDR_WIDTH  $clog2(RAM_SIZE)   byte-address width of all address ports
// DATA_WIDTH  32                 data width; fixed at 32 (4 byte lanes)
// PORTS
// clk            in   1           clock
// rstn_i         in   1           async active-low reset
// core_req_i     in   1           core request
// core_addr_i    in   ADDR_WIDTH  core byte address ([1:0] ignored)
// core_we_i      in   1           core write
// core_be_i      in   4           core byte enables
// core_wdata_i   in   32          core write data
// core_gnt_o     out  1           core grant, same cycle as RAM access
// core_rvalid_o  out  1           response valid, 1 cycle after every grant
// core_rdata_o   out  32          read data, valid with core_rvalid_o
// load_start_i   in   1           start pulse; sampled only in IDLE
// load_base_i    in   ADDR_WIDTH  load base byte address ([1:0] forced to 0)
// byte_valid_i   in   1           loader byte valid
// byte_data_i    in   8           loader byte
// byte_last_i    in   1           marks final byte of image
// byte_ready_o   out  1           loader byte accepted when valid&ready
// load_busy_o    out  1           high in FILL/WRITE/DONE
// load_done_o    out  1           1-cycle pulse on completion
// load_count_o   out  ADDR_WIDTH-2 words written by current/last load
// ram_en_o, ram_we_o  out 1       RAM enable / write
// ram_addr_o     out  ADDR_WIDTH  RAM byte address
// ram_wdata_o    out  32          RAM write data
// ram_be_o       out  4           RAM byte enables
// ram_rdata_i    in   32          RAM read data, 1-cycle latency after ram_en_o
// BEHAVIOUR
// - Reset: state IDLE; byte_ready_o, load_busy_o, load_done_o, core_rvalid_o = 0; load_count_o = 0;
//   lane, pointer, byte-enable and data accumulators cleared. Reset mid-load discards partial word, no write.
// - IDLE: combinational passthrough; ram_en_o = core_gnt_o = core_req_i, ram_* = core_*.
// - core_rvalid_o registered: = core_req_i & core_gnt_o of previous cycle (reads and writes);
//   core_rdata_o = ram_rdata_i (don't-care when rvalid low).
// - load_start_i in IDLE: core still granted that cycle; next state FILL; ptr = load_base_i>>2; lane = 0;
//   load_count_o cleared. load_start_i outside IDLE ignored.
// - FILL: byte_ready_o = 1, core_gnt_o = 0, ram_en_o = 0. Accepted byte -> data[lane*8+:8], be[lane]=1,
//   lane++. If lane was 3 or byte_last_i: -> WRITE, remember last flag.
// - WRITE: byte_ready_o = 0; ram_en_o = ram_we_o = 1, ram_addr_o = {ptr,2'b00}, ram_be_o = be acc,
//   ram_wdata_o = data acc. Then ptr++ (wraps to 0), load_count_o++, be/lane cleared; last ? DONE : FILL.
// - DONE: load_done_o = 1 for this cycle, core_gnt_o = 0; -> IDLE.
// - Partial final word writes only its filled lanes; untouched bytes of that RAM word preserved.
// - Loader throughput: 5 cycles per full word. Core waits (gnt=0) but keeps req; no request dropped.
// TESTING
// - Core write 0xDEADBEEF @0x100 be=4'hF, then read @0x100 -> gnt same cycle, rvalid next cycle, rdata 0xDEADBEEF.
// - Load base 0x40, bytes 01..08 (last on 08) -> RAM 0x40=0x04030201, 0x44=0x08070605; done pulse; count=2.
// - Preload 0x48=0xFFFFFFFF via core; load base 0x48, 1 byte 0xAA last -> ram_be_o=4'b0001, reads 0xFFFFFFAA.
// - core_req_i held during 8-byte load -> core_gnt_o=0 through DONE; granted first IDLE cycle after.
// - Base RAM_SIZE-4, 8 bytes -> 1st word @RAM_SIZE-4, 2nd word @0x0 (wrap); count=2.
// - Assert rstn_i low after 2 bytes accepted -> no RAM write, outputs at reset values, state IDLE.

Source files
------------

// File: rtl/sp_ram_load_arbiter_if.sv
// Bundle of the core LSU port, the byte-stream loader port and the RAM port.
// slave = arbiter side, master = environment side (core, loader and RAM).
interface sp_ram_load_arbiter_if #(
  parameter int ADDR_WIDTH = 15
);
  logic                  core_req_i;
  logic [ADDR_WIDTH-1:0] core_addr_i;
  logic                  core_we_i;
  logic [3:0]            core_be_i;
  logic [31:0]           core_wdata_i;
  logic                  core_gnt_o;
  logic                  core_rvalid_o;
  logic [31:0]           core_rdata_o;

  logic                  load_start_i;
  logic [ADDR_WIDTH-1:0] load_base_i;
  logic                  byte_valid_i;
  logic [7:0]            byte_data_i;
  logic                  byte_last_i;
  logic                  byte_ready_o;
  logic                  load_busy_o;
  logic                  load_done_o;
  logic [ADDR_WIDTH-3:0] load_count_o;

  logic                  ram_en_o;
  logic                  ram_we_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [31:0]           ram_wdata_o;
  logic [3:0]            ram_be_o;
  logic [31:0]           ram_rdata_i;

  modport slave (
    input  core_req_i, core_addr_i, core_we_i, core_be_i, core_wdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o,
    input  load_start_i, load_base_i, byte_valid_i, byte_data_i, byte_last_i,
    output byte_ready_o, load_busy_o, load_done_o, load_count_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o,
    input  ram_rdata_i
  );

  modport master (
    output core_req_i, core_addr_i, core_we_i, core_be_i, core_wdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o,
    output load_start_i, load_base_i, byte_valid_i, byte_data_i, byte_last_i,
    input  byte_ready_o, load_busy_o, load_done_o, load_count_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o,
    output ram_rdata_i
  );
endinterface

// File: rtl/sp_ram_load_arbiter.sv
// Front end of the single-port RAM: core passthrough when idle, otherwise packs
// loader bytes little-endian into words and writes them with byte enables.
module sp_ram_load_arbiter #(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rstn_i,
  sp_ram_load_arbiter_if.slave bus
);
  localparam int WAW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                state;
  logic [WAW-1:0]        ptr;
  logic [WAW-1:0]        count;
  logic [1:0]            lane;
  logic [3:0]            be_acc;
  logic [DATA_WIDTH-1:0] data_acc;
  logic                  last_q;
  logic                  rvalid_q;
  logic                  unused_base_lsb;

  assign unused_base_lsb = ^bus.load_base_i[1:0];

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      ptr      <= '0;
      count    <= '0;
      lane     <= '0;
      be_acc   <= '0;
      data_acc <= '0;
      last_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= bus.core_req_i & bus.core_gnt_o;
      case (state)
        IDLE: if (bus.load_start_i) begin
          state  <= FILL;
          ptr    <= bus.load_base_i[ADDR_WIDTH-1:2];
          count  <= '0;
          lane   <= '0;
          be_acc <= '0;
        end
        FILL: if (bus.byte_valid_i) begin
          data_acc[{lane, 3'b000} +: 8] <= bus.byte_data_i;
          be_acc[lane]                  <= 1'b1;
          lane                          <= lane + 2'd1;
          if (lane == 2'd3 || bus.byte_last_i) begin
            state  <= WRITE;
            last_q <= bus.byte_last_i;
          end
        end
        WRITE: begin
          // ptr is exactly word-address wide, so it wraps modulo RAM_SIZE/4
          ptr    <= ptr + 1'b1;
          count  <= count + 1'b1;
          be_acc <= '0;
          lane   <= '0;
          state  <= last_q ? DONE : FILL;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.core_gnt_o  = 1'b0;
    bus.ram_en_o    = 1'b0;
    bus.ram_we_o    = 1'b0;
    bus.ram_addr_o  = bus.core_addr_i;
    bus.ram_wdata_o = bus.core_wdata_i;
    bus.ram_be_o    = bus.core_be_i;
    case (state)
      IDLE: begin
        bus.core_gnt_o = bus.core_req_i;
        bus.ram_en_o   = bus.core_req_i;
        bus.ram_we_o   = bus.core_we_i;
      end
      WRITE: begin
        bus.ram_en_o    = 1'b1;
        bus.ram_we_o    = 1'b1;
        bus.ram_addr_o  = {ptr, 2'b00};
        bus.ram_wdata_o = data_acc;
        bus.ram_be_o    = be_acc;
      end
      default: ;
    endcase
  end

  assign bus.core_rvalid_o = rvalid_q;
  assign bus.core_rdata_o  = bus.ram_rdata_i;
  assign bus.byte_ready_o  = (state == FILL);
  assign bus.load_busy_o   = (state != IDLE);
  assign bus.load_done_o   = (state == DONE);
  assign bus.load_count_o  = count;
endmodule
